// File: rtl/fp_pkg.sv
// Shared floating-point constants and types for the FP datapaths.
package fp_pkg;
  localparam int FP_BIAS  = 127;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  typedef enum logic [1:0] {IDLE, NORM, PACK} state_t;
  typedef logic [31:0] fp_word_t;
endpackage

// File: rtl/fp_round_pack.sv
// Packs a normalised working word into IEEE754 single precision.
// FIXED_TO_FP_RNE_EN selects round-to-nearest-even; otherwise the mantissa is truncated.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int W = 25
) (
  input  logic                sign_r,
  input  logic [FP_EXP_W-1:0] exp,
  input  logic [W-1:0]        x,
  output fp_word_t            word
);

  logic [FP_MAN_W-1:0] man;
  logic                inc;
  logic [FP_MAN_W:0]   man_sum;
  logic [FP_EXP_W-1:0] exp_out;
  // two zero pads let guard/sticky indexing stay legal down to W=24
  logic [W+1:0]        x_ext;

  assign man   = x[W-2:W-1-FP_MAN_W];
  assign x_ext = {x, 2'b00};

`ifdef FIXED_TO_FP_RNE_EN
  logic guard;
  logic sticky;
  logic unused_lead;

  assign guard       = x_ext[W-23];
  assign sticky      = |x_ext[W-24:0];
  assign inc         = guard & (sticky | man[0]);
  assign unused_lead = x[W-1];
`else
  logic unused_bits;

  assign inc         = 1'b0;
  assign unused_bits = ^{x[W-1], x_ext[W-23:0]};
`endif

  assign man_sum = {1'b0, man} + {{FP_MAN_W{1'b0}}, inc};
  assign exp_out = exp + FP_EXP_W'(man_sum[FP_MAN_W]);
  assign word    = {sign_r, exp_out, man_sum[FP_MAN_W-1:0]};

endmodule

// File: rtl/fixed_to_fp.sv
// Iterative sign-magnitude fixed-point to IEEE754 single converter, one shift per clock.
// Rounding mode follows FIXED_TO_FP_RNE_EN (see fp_round_pack).
module fixed_to_fp
  import fp_pkg::*;
#(
  parameter int INT_W  = 5,
  parameter int FRAC_W = 20
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              sign,
  input  logic [INT_W-1:0]  nguyen,
  input  logic [FRAC_W-1:0] le,
  output logic [31:0]       out,
  output logic              done,
  output logic              busy
);

  localparam int W   = INT_W + FRAC_W;
  localparam int K_W = $clog2(W + 1);

  generate
    if (W < 24 || W > 64) begin : g_bad_width
      $error("fixed_to_fp: INT_W+FRAC_W must be within 24..64");
    end
  endgenerate

  state_t         state_q, state_d;
  logic [W-1:0]   x_q, x_d;
  logic [K_W-1:0] k_q, k_d;
  logic           sign_q, sign_d;
  fp_word_t       out_q, out_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;

  logic [FP_EXP_W-1:0] exp_raw;
  fp_word_t            packed_word;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      x_q     <= '0;
      k_q     <= '0;
      sign_q  <= 1'b0;
      out_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      k_q     <= k_d;
      sign_q  <= sign_d;
      out_q   <= out_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    k_d     = k_q;
    sign_d  = sign_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d  = sign;
          x_d     = {nguyen, le};
          k_d     = '0;
          state_d = ({nguyen, le} == '0) ? PACK : NORM;
        end
      end
      NORM: begin
        if (x_q[W-1]) begin
          state_d = PACK;
        end else begin
          x_d = x_q << 1;
          k_d = k_q + K_W'(1);
        end
      end
      PACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // exponent of the leading one before any rounding carry
  assign exp_raw = FP_EXP_W'(FP_BIAS + INT_W - 1) - FP_EXP_W'(k_q);

  fp_round_pack #(.W(W)) u_round_pack (
    .sign_r (sign_q),
    .exp    (exp_raw),
    .x      (x_q),
    .word   (packed_word)
  );

  always_comb begin
    out_d  = out_q;
    done_d = 1'b0;
    busy_d = 1'b0;
    case (state_q)
      IDLE: busy_d = start;
      NORM: busy_d = 1'b1;
      PACK: begin
        done_d = 1'b1;
        out_d  = (x_q == '0) ? {sign_q, 31'b0} : packed_word;
      end
      default: busy_d = 1'b0;
    endcase
  end

  assign out  = out_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_fixed_to_fp.sv
// Self-checking bench for fixed_to_fp; reference model uses plain integer arithmetic.
module tb_fixed_to_fp;

  localparam int INT_W  = 5;
  localparam int FRAC_W = 20;
  localparam int W      = INT_W + FRAC_W;

  logic              CLK = 1'b0;
  logic              RST;
  logic              start;
  logic              sign;
  logic [INT_W-1:0]  nguyen;
  logic [FRAC_W-1:0] le;
  logic [31:0]       out;
  logic              done;
  logic              busy;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  fixed_to_fp #(.INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .start  (start),
    .sign   (sign),
    .nguyen (nguyen),
    .le     (le),
    .out    (out),
    .done   (done),
    .busy   (busy)
  );

  function automatic int lead_pos(longint unsigned v);
    int p = -1;
    for (int i = 0; i < 64; i++) if (v[i]) p = i;
    return p;
  endfunction

  // value = v * 2^-FRAC_W, so the unbiased exponent is (leading position - FRAC_W)
  function automatic logic [31:0] ref_fp(logic s, logic [INT_W-1:0] n, logic [FRAC_W-1:0] l);
    longint unsigned v, m, rem, half;
    int p, e, sh;
    v = (longint'(n) << FRAC_W) | longint'(l);
    if (v == 0) return {s, 31'b0};
    p = lead_pos(v);
    e = p - FRAC_W;
    if (p >= 23) begin
      sh  = p - 23;
      m   = v >> sh;
      rem = v & ((64'd1 << sh) - 64'd1);
`ifdef FIXED_TO_FP_RNE_EN
      if (sh > 0) begin
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && m[0])) m = m + 1;
        if (m == (64'd1 << 24)) begin
          m = m >> 1;
          e = e + 1;
        end
      end
`else
      half = rem;
`endif
    end else begin
      m = v << (23 - p);
    end
    return {s, 8'(e + 127), m[22:0]};
  endfunction

  function automatic int ref_lat(logic [INT_W-1:0] n, logic [FRAC_W-1:0] l);
    longint unsigned v;
    v = (longint'(n) << FRAC_W) | longint'(l);
    if (v == 0) return 1;
    return 2 + (W - 1 - lead_pos(v));
  endfunction

  // Starts a conversion at #1 after an edge with the DUT idle; returns result and done latency.
  task automatic convert(input logic s, input logic [INT_W-1:0] n, input logic [FRAC_W-1:0] l,
                         output logic [31:0] o, output int lat);
    bit busy_bad = 1'b0;
    sign = s; nguyen = n; le = l; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      @(posedge CLK); #1;
      lat++;
    end
    o = out;
    total++;
    if (busy_bad) begin
      bad++;
      $display("FAIL busy_during_conv: busy=0 before done, required 1 (n=%0d l=%h)", n, l);
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL done_handshake: done=%b busy=%b, required done=1 busy=0", done, busy);
    end
    @(posedge CLK); #1;
    total++;
    if (done !== 1'b0 || out !== o) begin
      bad++;
      $display("FAIL done_pulse: done=%b out=%h, required done=0 out=%h", done, out, o);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; start = 1'b0; sign = 1'b0; nguyen = '0; le = '0;
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if (out !== 32'h0) begin bad++; $display("FAIL reset_out: got %h, required 00000000", out); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b, required 0", done); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_directed();
    logic              s_t[7];
    logic [INT_W-1:0]  n_t[7];
    logic [FRAC_W-1:0] l_t[7];
    logic [31:0]       e_t[7];
    int                lat_t[7];
    logic [31:0]       got;
    int                lat;
    s_t[0] = 0; n_t[0] = 1;  l_t[0] = 20'h0;     e_t[0] = 32'h3F800000; lat_t[0] = 6;
    s_t[1] = 0; n_t[1] = 5;  l_t[1] = 20'h80000; e_t[1] = 32'h40B00000; lat_t[1] = 4;
    s_t[2] = 1; n_t[2] = 5;  l_t[2] = 20'h80000; e_t[2] = 32'hC0B00000; lat_t[2] = 4;
    s_t[3] = 0; n_t[3] = 0;  l_t[3] = 20'h1;     e_t[3] = 32'h35800000; lat_t[3] = 26;
    s_t[4] = 1; n_t[4] = 0;  l_t[4] = 20'h0;     e_t[4] = 32'h80000000; lat_t[4] = 1;
`ifdef FIXED_TO_FP_RNE_EN
    s_t[5] = 0; n_t[5] = 31; l_t[5] = 20'hFFFFF; e_t[5] = 32'h42000000; lat_t[5] = 2;
`else
    s_t[5] = 0; n_t[5] = 31; l_t[5] = 20'hFFFFF; e_t[5] = 32'h41FFFFFF; lat_t[5] = 2;
`endif
    s_t[6] = 0; n_t[6] = 31; l_t[6] = 20'h0;     e_t[6] = 32'h41F80000; lat_t[6] = 2;
    for (int i = 0; i < 7; i++) begin
      convert(s_t[i], n_t[i], l_t[i], got, lat);
      total++;
      if (got !== e_t[i]) begin
        bad++;
        $display("FAIL directed_out[%0d]: got %h, required %h", i, got, e_t[i]);
      end
      total++;
      if (lat !== lat_t[i]) begin
        bad++;
        $display("FAIL directed_latency[%0d]: got %0d, required %0d", i, lat, lat_t[i]);
      end
    end
  endtask

  task automatic test_random();
    longint unsigned v;
    logic [INT_W-1:0]  n;
    logic [FRAC_W-1:0] l;
    logic              s;
    logic [31:0]       got;
    int                lat;
    for (int i = 0; i < 60; i++) begin
      v = {$urandom, $urandom};
      v = (v >> $urandom_range(0, 40)) & ((64'd1 << W) - 64'd1);
      n = v[W-1:FRAC_W];
      l = v[FRAC_W-1:0];
      s = 1'($urandom_range(0, 1));
      convert(s, n, l, got, lat);
      total++;
      if (got !== ref_fp(s, n, l)) begin
        bad++;
        $display("FAIL random_out: n=%0d l=%h s=%b got %h, required %h", n, l, s, got, ref_fp(s, n, l));
      end
      total++;
      if (lat !== ref_lat(n, l)) begin
        bad++;
        $display("FAIL random_latency: n=%0d l=%h got %0d, required %0d", n, l, lat, ref_lat(n, l));
      end
    end
  endtask

  task automatic test_start_held();
    int  lat = 0;
    bit  stray = 1'b0;
    sign = 1'b0; nguyen = '0; le = 20'h1; start = 1'b1;
    @(posedge CLK); #1;
    nguyen = 5'd31; le = 20'hFFFFF; sign = 1'b1;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge CLK); #1;
      lat++;
      if (lat == 10) start = 1'b0;
    end
    total++;
    if (out !== ref_fp(1'b0, 5'd0, 20'h1)) begin
      bad++;
      $display("FAIL start_held_out: got %h, required %h", out, ref_fp(1'b0, 5'd0, 20'h1));
    end
    total++;
    if (lat !== 26) begin bad++; $display("FAIL start_held_latency: got %0d, required 26", lat); end
    repeat (6) begin
      @(posedge CLK); #1;
      if (done === 1'b1 || busy === 1'b1) stray = 1'b1;
    end
    total++;
    if (stray) begin bad++; $display("FAIL start_held_queued: extra conversion seen, required none"); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    int          lat;
    convert(1'b0, 5'd3, 20'h40000, got, lat);
    total++;
    if (got !== 32'h40500000) begin bad++; $display("FAIL b2b_first: got %h, required 40500000", got); end
    convert(1'b1, 5'd0, 20'h00300, got, lat);
    total++;
    if (got !== ref_fp(1'b1, 5'd0, 20'h00300)) begin
      bad++;
      $display("FAIL b2b_second: got %h, required %h", got, ref_fp(1'b1, 5'd0, 20'h00300));
    end
    total++;
    if (lat !== ref_lat(5'd0, 20'h00300)) begin
      bad++;
      $display("FAIL b2b_latency: got %0d, required %0d", lat, ref_lat(5'd0, 20'h00300));
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    sign = 1'b1; nguyen = '0; le = 20'h1; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b, required 1", busy); end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset: busy=%b done=%b out=%h, required 0 0 00000000", busy, done, out);
    end
    repeat (40) begin
      @(posedge CLK); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL mid_reset_done: done pulse after abort, required none"); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_held();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
